// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the instruction-cache refill controller.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        REPLAY = 2'd2
    } state_e;

    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_length, input int sets, input int line_words);
        return addr_length - 2 - $clog2(sets) - $clog2(line_words);
    endfunction

    // A direct-mapped cache still needs a one-bit way select.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Per-set round-robin replacement pointers; an invalid way always wins over the pointer.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic [index_bits(SETS)-1:0]    i_idx,
    input  logic [WAYS-1:0]                i_set_valid,
    output logic [way_bits(WAYS)-1:0]      o_victim,
    input  logic                           i_adv,
    input  logic [index_bits(SETS)-1:0]    i_adv_idx
);
    localparam int WB = way_bits(WAYS);

    logic [WB-1:0] ptr_q [SETS];
    logic [WB-1:0] adv_ptr;

    always_comb begin
        o_victim = ptr_q[i_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_set_valid[w]) begin
                o_victim = WB'(w);
            end
        end
    end

    assign adv_ptr = ptr_q[i_adv_idx];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (i_adv) begin
            ptr_q[i_adv_idx] <= (adv_ptr == WB'(WAYS - 1)) ? '0 : adv_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Set-associative instruction cache front end: hit lookup, line refill from the MMU,
// single-cycle replay of the missed word, emulation bypass and deferred flush.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int WAYS        = 4,
    parameter int SETS        = 16,
    parameter int LINE_WORDS  = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int INSTR_SIZE  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_fetch,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    input  logic                   i_emul_mode,
    input  logic [INSTR_SIZE-1:0]  i_emul_instr,
    input  logic                   i_flush,
    output logic [INSTR_SIZE-1:0]  o_instr,
    output logic                   o_valid,
    output logic                   o_stall,
    output logic                   o_miss,
    output logic                   o_mmu_req,
    output logic [ADDR_LENGTH-1:0] o_mmu_addr,
    input  logic                   i_mmu_we,
    input  logic [INSTR_SIZE-1:0]  i_mmu_data,
    output logic                   o_dbg_evict_valid,
    output logic [ADDR_LENGTH-1:0] o_dbg_evict_addr
);
    localparam int OB = offset_bits(LINE_WORDS);
    localparam int IB = index_bits(SETS);
    localparam int TB = tag_bits(ADDR_LENGTH, SETS, LINE_WORDS);
    localparam int WB = way_bits(WAYS);

    logic [TB-1:0]         tag_mem  [WAYS][SETS];
    logic [INSTR_SIZE-1:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]       line_valid_q [SETS];

    state_e                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [WB-1:0]          way_q;
    logic [OB-1:0]          beat_q;
    logic                   flush_pend_q;
    logic [INSTR_SIZE-1:0]  instr_q;
    logic                   out_valid_q, miss_q, evict_valid_q;
    logic [ADDR_LENGTH-1:0] evict_addr_q;

    logic [OB-1:0] req_off, off_q;
    logic [IB-1:0] req_idx, idx_q;
    logic [TB-1:0] req_tag, tag_q;
    logic [WAYS-1:0] way_hit, set_valid;
    logic [WB-1:0]   hit_way, victim_way;
    logic fetch_ok, hit, emul_go, hit_go, miss_go, beat_go, last_beat, clear_all;
    logic unused_bits;

    assign req_off = i_addr[OB+1:2];
    assign req_idx = i_addr[OB+IB+1:OB+2];
    assign req_tag = i_addr[ADDR_LENGTH-1:OB+IB+2];
    assign off_q   = addr_q[OB+1:2];
    assign idx_q   = addr_q[OB+IB+1:OB+2];
    assign tag_q   = addr_q[ADDR_LENGTH-1:OB+IB+2];
    assign unused_bits = ^{i_addr[1:0], addr_q[1:0]};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
            assign way_hit[gi] = line_valid_q[req_idx][gi] && (tag_mem[gi][req_idx] == req_tag);
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_way = WB'(w);
            end
        end
    end

    // A flush in the lookup cycle makes the whole set look empty: forced miss, no eviction.
    assign set_valid = i_flush ? '0 : line_valid_q[req_idx];
    assign hit       = (|way_hit) && !i_flush;
    assign fetch_ok  = i_fetch && (state_q == IDLE);
    assign emul_go   = fetch_ok && i_emul_mode;
    assign hit_go    = fetch_ok && !i_emul_mode && hit;
    assign miss_go   = fetch_ok && !i_emul_mode && !hit;
    assign beat_go   = (state_q == REFILL) && i_mmu_we;
    assign last_beat = beat_go && (beat_q == OB'(LINE_WORDS - 1));
    assign clear_all = ((state_q == IDLE) && i_flush)
                     || ((state_q == REPLAY) && (flush_pend_q || i_flush));

    icache_victim_sel #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_victim_sel (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_idx       (req_idx),
        .i_set_valid (set_valid),
        .o_victim    (victim_way),
        .i_adv       (last_beat),
        .i_adv_idx   (idx_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_go) state_d = REFILL;
            REFILL:  if (last_beat) state_d = REPLAY;
            REPLAY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (beat_go) begin
            data_mem[way_q][idx_q][beat_q] <= i_mmu_data;
        end
        if (last_beat) begin
            tag_mem[way_q][idx_q] <= tag_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            way_q         <= '0;
            beat_q        <= '0;
            flush_pend_q  <= 1'b0;
            instr_q       <= '0;
            out_valid_q   <= 1'b0;
            miss_q        <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                line_valid_q[s] <= '0;
            end
        end else begin
            state_q       <= state_d;
            out_valid_q   <= emul_go || hit_go || last_beat;
            miss_q        <= miss_go;
            evict_valid_q <= miss_go && set_valid[victim_way];
            if (miss_go) begin
                addr_q <= i_addr;
                way_q  <= victim_way;
                beat_q <= '0;
                if (set_valid[victim_way]) begin
                    evict_addr_q <= {tag_mem[victim_way][req_idx], req_idx, {(OB + 2){1'b0}}};
                end
            end
            if (emul_go) begin
                instr_q <= i_emul_instr;
            end else if (hit_go) begin
                instr_q <= data_mem[hit_way][req_idx][req_off];
            end
            // The requested word is captured as it streams past, ready for the replay cycle.
            if (beat_go) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q == off_q) begin
                    instr_q <= i_mmu_data;
                end
            end
            if ((state_q == REFILL) && i_flush) begin
                flush_pend_q <= 1'b1;
            end else if (state_q == REPLAY) begin
                flush_pend_q <= 1'b0;
            end
            if (last_beat) begin
                line_valid_q[idx_q][way_q] <= 1'b1;
            end
            if (clear_all) begin
                for (int s = 0; s < SETS; s++) begin
                    line_valid_q[s] <= '0;
                end
            end
        end
    end

    assign o_instr           = instr_q;
    assign o_valid           = out_valid_q;
    assign o_miss            = miss_q;
    assign o_stall           = (state_q == REFILL);
    assign o_mmu_req         = (state_q == REFILL);
    assign o_mmu_addr        = {addr_q[ADDR_LENGTH-1:OB+2], {(OB + 2){1'b0}}};
    assign o_dbg_evict_valid = evict_valid_q;
    assign o_dbg_evict_addr  = evict_addr_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed and randomized fetch/refill sequences checked against a per-set line model.
module tb_icache_refill_ctrl;
    localparam int WAYS = 4;
    localparam int SETS = 16;
    localparam int LW   = 8;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b1;
    logic        i_fetch = 1'b0, i_emul_mode = 1'b0, i_flush = 1'b0, i_mmu_we = 1'b0;
    logic [31:0] i_addr = '0, i_emul_instr = '0, i_mmu_data = '0;
    logic [31:0] o_instr, o_mmu_addr, o_dbg_evict_addr;
    logic        o_valid, o_stall, o_miss, o_mmu_req, o_dbg_evict_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_tag  [SETS][WAYS];
    bit          m_val  [SETS][WAYS];
    logic [31:0] m_data [SETS][WAYS][LW];
    int          m_ptr  [SETS];
    logic [31:0] m_evict;
    logic [31:0] p_addr;
    int          p_way;
    bit          missed;

    always #5 i_clk = ~i_clk;

    icache_refill_ctrl #(
        .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_LENGTH(32), .INSTR_SIZE(32)
    ) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_fetch(i_fetch), .i_addr(i_addr),
        .i_emul_mode(i_emul_mode), .i_emul_instr(i_emul_instr), .i_flush(i_flush),
        .o_instr(o_instr), .o_valid(o_valid), .o_stall(o_stall), .o_miss(o_miss),
        .o_mmu_req(o_mmu_req), .o_mmu_addr(o_mmu_addr), .i_mmu_we(i_mmu_we),
        .i_mmu_data(i_mmu_data), .o_dbg_evict_valid(o_dbg_evict_valid),
        .o_dbg_evict_addr(o_dbg_evict_addr)
    );

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 5) % SETS);
    endfunction
    function automatic int off_of(input logic [31:0] a);
        return int'((a >> 2) % LW);
    endfunction
    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 9;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
        m_evict = '0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_instr"}, o_instr, 0);
        chk({name, "_ctl"}, {o_valid, o_stall, o_miss, o_mmu_req, o_dbg_evict_valid}, 0);
        chk({name, "_addrs"}, {o_mmu_addr, o_dbg_evict_addr}, 0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit emul, input logic [31:0] ei,
                            input bit fl, output bit was_miss);
        int s, hw, vic;
        bit ev;
        s = set_of(a);
        i_fetch = 1'b1; i_addr = a; i_emul_mode = emul; i_emul_instr = ei; i_flush = fl;
        tick();
        i_fetch = 1'b0; i_emul_mode = 1'b0; i_flush = 1'b0;
        if (fl) m_flush();
        was_miss = 1'b0;
        if (emul) begin
            chk("emul_instr", o_instr, ei);
            chk("emul_ctl", {o_valid, o_miss, o_stall, o_mmu_req}, 4'b1000);
            $display("fetch %h emul -> instr %h valid %0b", a, o_instr, o_valid);
            return;
        end
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_val[s][w] && m_tag[s][w] == tag_of(a)) hw = w;
        if (hw >= 0) begin
            chk("hit_instr", o_instr, m_data[s][hw][off_of(a)]);
            chk("hit_ctl", {o_valid, o_miss, o_stall, o_mmu_req}, 4'b1000);
            $display("fetch %h hit -> instr %h", a, o_instr);
            return;
        end
        vic = m_ptr[s];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_val[s][w]) vic = w;
        ev = m_val[s][vic];
        if (ev) m_evict = (m_tag[s][vic] << 9) | (32'(s) << 5);
        chk("miss_ctl", {o_valid, o_miss, o_stall, o_mmu_req}, 4'b0111);
        chk("miss_mmu_addr", o_mmu_addr, a & 32'hFFFF_FFE0);
        chk("evict_valid", o_dbg_evict_valid, ev);
        chk("evict_addr", o_dbg_evict_addr, m_evict);
        $display("fetch %h miss -> mmu_addr %h evict %0b/%h", a, o_mmu_addr,
                 o_dbg_evict_valid, o_dbg_evict_addr);
        p_addr = a;
        p_way = vic;
        was_miss = 1'b1;
    endtask

    // gap < 0 picks 0..2 idle cycles per beat; flush_beat/rst_beat < 0 disables that event.
    task automatic do_refill(input int gap, input int flush_beat, input int rst_beat,
                             input logic [31:0] base);
        logic [31:0] line [LW];
        logic [31:0] la;
        int s, ng;
        s = set_of(p_addr);
        la = p_addr & 32'hFFFF_FFE0;
        for (int b = 0; b < LW; b++) line[b] = (base != 0) ? base + 32'(b) : $urandom;
        for (int b = 0; b < LW; b++) begin
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (ng) begin
                tick();
                chk("gap_mmu", {o_mmu_req, o_stall, o_mmu_addr}, {2'b11, la});
            end
            if (b == rst_beat) begin
                i_mmu_we = 1'b1; i_mmu_data = line[b]; i_nrst = 1'b0;
                #1;
                chk_reset_outputs("rst_in_refill");
                $display("refill %h reset at beat %0d", la, b);
                i_mmu_we = 1'b0;
                repeat (2) @(posedge i_clk);
                #1 i_nrst = 1'b1;
                m_reset();
                return;
            end
            i_mmu_we = 1'b1; i_mmu_data = line[b]; i_flush = (b == flush_beat);
            tick();
            i_mmu_we = 1'b0; i_flush = 1'b0;
            if (b < LW - 1) chk("beat_mmu", {o_mmu_req, o_stall, o_mmu_addr}, {2'b11, la});
        end
        chk("replay_instr", o_instr, line[off_of(p_addr)]);
        chk("replay_ctl", {o_valid, o_miss, o_stall, o_mmu_req}, 4'b1000);
        $display("refill %h done -> replay instr %h", la, o_instr);
        m_tag[s][p_way] = tag_of(p_addr);
        m_val[s][p_way] = 1'b1;
        for (int b = 0; b < LW; b++) m_data[s][p_way][b] = line[b];
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        if (flush_beat >= 0) m_flush();
        tick();
        chk("post_replay_valid", o_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #2 i_nrst = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge i_clk);
        #1 i_nrst = 1'b1;

        // Cold miss, refill with 0xA0..0xA7, then a hit in the same line
        do_fetch(32'h0000_1004, 1'b0, '0, 1'b0, missed);
        chk("cold_is_miss", missed, 1'b1);
        do_refill(0, -1, -1, 32'hA0);
        do_fetch(32'h0000_1008, 1'b0, '0, 1'b0, missed);
        chk("refetch_hit_instr", o_instr, 32'hA2);

        // Fill set 0 and force a round-robin eviction of 0x1000
        do_fetch(32'h0000_1200, 1'b0, '0, 1'b0, missed); do_refill(-1, -1, -1, 0);
        do_fetch(32'h0000_1400, 1'b0, '0, 1'b0, missed); do_refill(-1, -1, -1, 0);
        do_fetch(32'h0000_1600, 1'b0, '0, 1'b0, missed); do_refill(-1, -1, -1, 0);
        do_fetch(32'h0000_1800, 1'b0, '0, 1'b0, missed);
        chk("evict_0x1000", {o_dbg_evict_valid, o_dbg_evict_addr}, {1'b1, 32'h0000_1000});
        do_refill(-1, -1, -1, 0);

        // Emulation bypass at a missing address
        do_fetch(32'h4444_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, missed);

        // Flush during beat 3: replay still correct, line gone afterwards
        do_fetch(32'h0000_2010, 1'b0, '0, 1'b0, missed);
        do_refill(0, 3, -1, 0);
        do_fetch(32'h0000_2014, 1'b0, '0, 1'b0, missed);
        chk("miss_after_flush", missed, 1'b1);
        do_refill(-1, -1, -1, 0);

        // Two idle cycles between beats; stray beats in IDLE are ignored
        do_fetch(32'h0000_3000, 1'b0, '0, 1'b0, missed);
        do_refill(2, -1, -1, 0);
        i_mmu_we = 1'b1; i_mmu_data = $urandom;
        repeat (3) tick();
        i_mmu_we = 1'b0;
        chk("idle_we_ctl", {o_valid, o_miss, o_stall, o_mmu_req}, 4'b0000);
        do_fetch(32'h0000_301C, 1'b0, '0, 1'b0, missed);
        chk("hit_after_idle_we", missed, 1'b0);

        // Flush in IDLE, and fetch in the same cycle as flush
        i_flush = 1'b1; tick(); i_flush = 1'b0; m_flush();
        do_fetch(32'h0000_3000, 1'b0, '0, 1'b0, missed);
        chk("miss_after_idle_flush", missed, 1'b1);
        do_refill(-1, -1, -1, 0);
        do_fetch(32'h0000_3004, 1'b0, '0, 1'b1, missed);
        chk("fetch_with_flush_miss", missed, 1'b1);
        do_refill(-1, -1, -1, 0);

        // Reset at beat 5 abandons the refill
        do_fetch(32'h0000_5000, 1'b0, '0, 1'b0, missed);
        do_refill(0, -1, 5, 0);
        do_fetch(32'h0000_5000, 1'b0, '0, 1'b0, missed);
        chk("miss_after_reset", missed, 1'b1);
        do_refill(-1, -1, -1, 0);

        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            bit em, fl;
            int fb;
            a = (32'($urandom_range(8, 13)) << 9) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            em = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) begin
                i_flush = 1'b1; tick(); i_flush = 1'b0; m_flush();
            end
            do_fetch(a, em, $urandom, fl, missed);
            if (missed) begin
                fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
                do_refill(-1, fb, -1, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
